piso8_tx: RTL

Parallel-in, serial-out transmitter that feeds the team's serial shift-register receiver chain. It accepts parallel words over a valid/ready handshake and shifts them out MSB first, one bit per clock. A receiver that shifts left and inserts at bit 0 therefore reassembles the word in original order. A one-word holding buffer allows gapless back-to-back frames.

---
 rtl/piso8_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/piso8_tx.sv
// piso8_tx: valid/ready parallel-in, MSB-first serial-out transmitter with a one-word hold buffer.
// Optional feature macro PISO8_TX_PARITY_EN appends an even-parity bit to every frame.
`default_nettype none

module piso8_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             out,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

`ifdef PISO8_TX_PARITY_EN
   localparam int C_FRAME = WIDTH + 1;
`else
   localparam int C_FRAME = WIDTH;
`endif
   localparam int            C_CW       = $clog2(WIDTH + 2);
   localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(C_FRAME - 1);
   localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_sh, w_sh_nx;
   logic [WIDTH-1:0] r_hold, w_hold_nx;
   logic [C_CW-1:0]  r_cnt, w_cnt_nx;
   logic             r_hold_full, w_hold_full_nx;
   logic             r_out, w_out_nx;
   logic             r_out_valid, w_out_valid_nx;
   logic             r_out_last, w_out_last_nx;
   logic             w_accept;
   logic             w_load;
   logic [WIDTH-1:0] w_load_word;
`ifdef PISO8_TX_PARITY_EN
   logic             r_par, w_par_nx;
`endif

   always_comb begin
      w_accept        = din_valid && !r_hold_full;
      w_state_nx      = r_state;
      w_sh_nx         = r_sh;
      w_hold_nx       = r_hold;
      w_cnt_nx        = r_cnt;
      w_hold_full_nx  = r_hold_full;
      w_out_nx        = r_out;
      w_out_valid_nx  = r_out_valid;
      w_out_last_nx   = r_out_last;
      w_load          = 1'b0;
      w_load_word     = din;
`ifdef PISO8_TX_PARITY_EN
      w_par_nx        = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
            end
         end
         S_SHIFT: begin
            if (r_cnt == '0) begin
               // Last bit on the wire: chain the next word in without a gap if one is available.
               if (r_hold_full) begin
                  w_load         = 1'b1;
                  w_load_word    = r_hold;
                  w_hold_full_nx = 1'b0;
               end else if (w_accept) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nx     = S_IDLE;
                  w_out_nx       = 1'b0;
                  w_out_valid_nx = 1'b0;
                  w_out_last_nx  = 1'b0;
               end
            end else begin
               w_sh_nx       = r_sh << 1;
               w_cnt_nx      = r_cnt - 1'b1;
               w_out_nx      = r_sh[WIDTH-2];
               w_out_last_nx = (r_cnt == C_CNT_ONE);
`ifdef PISO8_TX_PARITY_EN
               if (r_cnt == C_CNT_ONE) begin
                  w_out_nx = r_par;
               end
`endif
               if (w_accept) begin
                  w_hold_nx      = din;
                  w_hold_full_nx = 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      if (w_load) begin
         w_state_nx     = S_SHIFT;
         w_sh_nx        = w_load_word;
         w_cnt_nx       = C_CNT_LOAD;
         w_out_nx       = w_load_word[WIDTH-1];
         w_out_valid_nx = 1'b1;
         w_out_last_nx  = 1'b0;
`ifdef PISO8_TX_PARITY_EN
         w_par_nx       = ^w_load_word;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sh        <= '0;
         r_hold      <= '0;
         r_cnt       <= '0;
         r_hold_full <= 1'b0;
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef PISO8_TX_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_sh        <= w_sh_nx;
         r_hold      <= w_hold_nx;
         r_cnt       <= w_cnt_nx;
         r_hold_full <= w_hold_full_nx;
         r_out       <= w_out_nx;
         r_out_valid <= w_out_valid_nx;
         r_out_last  <= w_out_last_nx;
`ifdef PISO8_TX_PARITY_EN
         r_par       <= w_par_nx;
`endif
      end
   end

   assign din_ready = !r_hold_full;
   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = (r_state == S_SHIFT) || r_hold_full;

endmodule

`default_nettype wire
